// File: rtl/s2c_pkg.sv
// Shared types and constants for the multi-channel S2C call mux.
package s2c_pkg;

  typedef logic [31:0] uint32_t;

  localparam uint32_t S2C_ERR_RET = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT,
    DONE
  } s2c_state_e;

  typedef struct packed {
    uint32_t id;
    uint32_t fn;
    uint32_t ret;
  } s2c_call_t;

endpackage

// File: rtl/s2c_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves to grant+1 (mod NCH) when advance is strobed.
module s2c_rr_arb #(
  parameter int unsigned NCH = 4,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic           any,
  output logic [CHW-1:0] grant
);

  logic [CHW-1:0] ptr_q;

  // Search starting at the pointer and wrapping around.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!any && req[(32'(ptr_q) + i) % NCH]) begin
        any   = 1'b1;
        grant = CHW'((32'(ptr_q) + i) % NCH);
      end
    end
  end

  // Pointer update on an accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/s2c_call_mux.sv
// Multi-channel S2C call mux: round-robin arbitration of NCH callers onto a
// single S2C bridge, payload collection and one-cycle ack to the owner.
// Optional watchdog: define S2C_CALL_TIMEOUT_EN.
module s2c_call_mux
  import s2c_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DATA_WORDS  = 16,
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH*32-1:0]        ch_id,
  input  logic [NCH*32-1:0]        ch_fn,
  output logic [NCH-1:0]           ch_ack,
  output logic [31:0]              ch_ret,
  output logic [DATA_WORDS*32-1:0] ch_data,
  output logic                     ch_err,
  output logic                     call_valid,
  input  logic                     call_ready,
  output logic [31:0]              call_id,
  output logic [31:0]              call_fn,
  output logic [CHW-1:0]           call_ch,
  input  logic                     rsp_valid,
  input  logic                     rsp_last,
  input  logic [31:0]              rsp_ret,
  input  logic [31:0]              rsp_data,
  output logic                     busy
);

  localparam int unsigned BW = $clog2(DATA_WORDS + 1);
  localparam int unsigned IW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  s2c_state_e                   state_q, state_d;
  s2c_call_t                    call_q;
  logic [CHW-1:0]               ch_q;
  logic [CHW-1:0]               grant;
  logic                         any_req;
  logic                         take;
  logic                         wd_fire;
  logic [BW-1:0]                beat_q;
  logic [DATA_WORDS-1:0][31:0]  word_q;

  assign take = (state_q == IDLE) && any_req;

  s2c_rr_arb #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (ch_req),
    .advance (take),
    .any     (any_req),
    .grant   (grant)
  );

  assign busy    = (state_q != IDLE);
  assign call_id = call_q.id;
  assign call_fn = call_q.fn;
  assign call_ch = ch_q;
  assign ch_ret  = call_q.ret;
  assign ch_data = word_q;

`ifdef S2C_CALL_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_q;
  logic           wd_active;
  logic           wd_evt;
  logic           err_q;

  assign wd_active = (state_q == ISSUE) || (state_q == COLLECT);
  assign wd_evt    = ((state_q == ISSUE) && call_ready) ||
                     ((state_q == COLLECT) && rsp_valid);
  assign wd_fire   = wd_active && !wd_evt && (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign ch_err    = err_q;

  // Watchdog: counts idle cycles while waiting on the bridge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (wd_active && !wd_evt) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end

  // Error flag: cleared at grant, set on watchdog expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (take) begin
      err_q <= 1'b0;
    end else if (wd_fire) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign ch_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    call_valid = 1'b0;
    ch_ack     = '0;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE: begin
        call_valid = 1'b1;
        if (call_ready)   state_d = COLLECT;
        else if (wd_fire) state_d = DONE;
      end
      COLLECT: begin
        if (rsp_valid && rsp_last) state_d = DONE;
        else if (wd_fire)          state_d = DONE;
      end
      DONE: begin
        ch_ack[ch_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Call latch at grant, payload/ret capture during COLLECT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      call_q <= '0;
      ch_q   <= '0;
      beat_q <= '0;
      word_q <= '0;
    end else if (take) begin
      call_q.id  <= ch_id[32*grant +: 32];
      call_q.fn  <= ch_fn[32*grant +: 32];
      call_q.ret <= '0;
      ch_q       <= grant;
      beat_q     <= '0;
      word_q     <= '0;
    end else if (wd_fire) begin
      call_q.ret <= S2C_ERR_RET;
    end else if ((state_q == COLLECT) && rsp_valid) begin
      if (beat_q < BW'(DATA_WORDS)) begin
        word_q[beat_q[IW-1:0]] <= rsp_data;
        beat_q                 <= beat_q + 1'b1;
      end
      if (beat_q == '0) call_q.ret <= rsp_ret;
    end
  end

endmodule

// File: tb/tb_s2c_call_mux.sv
// Directed self-checking bench for s2c_call_mux (NCH=4, DATA_WORDS=16).
// With S2C_CALL_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYC=8.
module tb_s2c_call_mux;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    ch_req;
  logic [127:0]  ch_id;
  logic [127:0]  ch_fn;
  logic [3:0]    ch_ack;
  logic [31:0]   ch_ret;
  logic [511:0]  ch_data;
  logic          ch_err;
  logic          call_valid;
  logic          call_ready;
  logic [31:0]   call_id;
  logic [31:0]   call_fn;
  logic [1:0]    call_ch;
  logic          rsp_valid;
  logic          rsp_last;
  logic [31:0]   rsp_ret;
  logic [31:0]   rsp_data;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0]  bdata [32];
  logic [511:0] exp_data;

  s2c_call_mux #(
    .NCH         (4),
    .DATA_WORDS  (16),
`ifdef S2C_CALL_TIMEOUT_EN
    .TIMEOUT_CYC (8)
`else
    .TIMEOUT_CYC (1024)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_req     (ch_req),
    .ch_id      (ch_id),
    .ch_fn      (ch_fn),
    .ch_ack     (ch_ack),
    .ch_ret     (ch_ret),
    .ch_data    (ch_data),
    .ch_err     (ch_err),
    .call_valid (call_valid),
    .call_ready (call_ready),
    .call_id    (call_id),
    .call_fn    (call_fn),
    .call_ch    (call_ch),
    .rsp_valid  (rsp_valid),
    .rsp_last   (rsp_last),
    .rsp_ret    (rsp_ret),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    ch_req = '0; call_ready = 1'b1;
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_ret = '0; rsp_data = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Bounded wait until the DUT presents a call to the bridge.
  task automatic wait_call(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (call_valid) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s wait_call: call_valid=0, required 1 within 50 cycles", name);
    end
  endtask

  // Bridge side: n beats from bdata[], ret on beat 0 only, last on beat n-1.
  task automatic run_rsp(input logic [31:0] ret, input int n);
    for (int b = 0; b < n; b++) begin
      rsp_valid = 1'b1;
      rsp_data  = bdata[b];
      rsp_ret   = (b == 0) ? ret : 32'hBAD0_0000 + 32'(b);
      rsp_last  = (b == n - 1);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_data = '0; rsp_ret = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_req = '0; ch_id = '0; ch_fn = '0; call_ready = 1'b1;
    rsp_valid = 1'b0; rsp_last = 1'b0; rsp_ret = '0; rsp_data = '0;
    #12;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_chk++; if (ch_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0000", ch_ack); end
    n_chk++; if (call_valid !== 1'b0) begin n_fail++; $display("FAIL reset_call_valid: got %b required 0", call_valid); end
    n_chk++; if (ch_ret !== 32'h0 || call_id !== 32'h0 || call_fn !== 32'h0 || ch_err !== 1'b0)
      begin n_fail++; $display("FAIL reset_regs: ret=%h id=%h fn=%h err=%b required all 0", ch_ret, call_id, call_fn, ch_err); end
    n_chk++; if (ch_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h required 0", ch_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_call();
    ch_id[31:0] = 32'd7; ch_fn[31:0] = 32'd2;
    ch_req = 4'b0001;
    wait_call("single");
    n_chk++; if (call_id !== 32'd7 || call_fn !== 32'd2 || call_ch !== 2'd0)
      begin n_fail++; $display("FAIL single_issue: id=%0d fn=%0d ch=%0d required 7 2 0", call_id, call_fn, call_ch); end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      bdata[i] = 32'(i);
      exp_data[32*i +: 32] = 32'(i);
    end
    run_rsp(32'd5, 16);
    n_chk++; if (ch_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b required 0001", ch_ack); end
    n_chk++; if (ch_ret !== 32'd5 || ch_err !== 1'b0) begin n_fail++; $display("FAIL single_ret: ret=%0d err=%b required 5 0", ch_ret, ch_err); end
    n_chk++; if (ch_data !== exp_data) begin n_fail++; $display("FAIL single_data: got %h required %h", ch_data, exp_data); end
    ch_req = 4'b0000;
    @(posedge clk); #1;
    n_chk++; if (ch_ack !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: ack=%b busy=%b required 0000 0", ch_ack, busy); end
  endtask

  task automatic test_round_robin();
    int exp_ch [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      ch_id[32*i +: 32] = 32'(100 + i);
      ch_fn[32*i +: 32] = 32'(200 + i);
    end
    ch_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_call("rr");
      n_chk++; if (call_ch !== 2'(exp_ch[k]) || call_id !== 32'(100 + exp_ch[k]))
        begin n_fail++; $display("FAIL rr_grant%0d: ch=%0d id=%0d required %0d %0d", k, call_ch, call_id, exp_ch[k], 100 + exp_ch[k]); end
      @(posedge clk); #1;
      bdata[0] = 32'(k);
      run_rsp(32'(50 + k), 1);
      n_chk++; if (ch_ack !== (4'b0001 << exp_ch[k]) || ch_ret !== 32'(50 + k))
        begin n_fail++; $display("FAIL rr_ack%0d: ack=%b ret=%0d required %b %0d", k, ch_ack, ch_ret, 4'b0001 << exp_ch[k], 50 + k); end
      @(posedge clk); #1;
      n_chk++; if (ch_ack !== 4'b0) begin n_fail++; $display("FAIL rr_pulse%0d: ack=%b required 0000", k, ch_ack); end
    end
    ch_req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_payload_bounds();
    apply_reset();
    ch_req = 4'b0001;
    // 20 beats: the last four fall past the payload and are dropped.
    wait_call("over");
    @(posedge clk); #1;
    for (int b = 0; b < 20; b++) bdata[b] = 32'h1000 + 32'(b);
    for (int i = 0; i < 16; i++) exp_data[32*i +: 32] = 32'h1000 + 32'(i);
    run_rsp(32'h11, 20);
    n_chk++; if (ch_ack !== 4'b0001 || ch_ret !== 32'h11) begin n_fail++; $display("FAIL over_ack: ack=%b ret=%h required 0001 11", ch_ack, ch_ret); end
    n_chk++; if (ch_data !== exp_data) begin n_fail++; $display("FAIL over_data: got %h required %h", ch_data, exp_data); end
    // Short response after a full one: unwritten words must read back 0.
    wait_call("short");
    @(posedge clk); #1;
    bdata[0] = 32'hA; bdata[1] = 32'hB; bdata[2] = 32'hC;
    exp_data = '0;
    exp_data[31:0] = 32'hA; exp_data[63:32] = 32'hB; exp_data[95:64] = 32'hC;
    run_rsp(32'h22, 3);
    n_chk++; if (ch_ack !== 4'b0001 || ch_ret !== 32'h22) begin n_fail++; $display("FAIL short_ack: ack=%b ret=%h required 0001 22", ch_ack, ch_ret); end
    n_chk++; if (ch_data !== exp_data) begin n_fail++; $display("FAIL short_data: got %h required %h", ch_data, exp_data); end
    ch_req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    apply_reset();
    call_ready = 1'b0;
    ch_id[31:0] = 32'h55; ch_fn[31:0] = 32'h66;
    ch_req = 4'b0001;
    wait_call("bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_chk++; if (call_valid !== 1'b1 || call_id !== 32'h55 || call_fn !== 32'h66 || ch_ack !== 4'b0)
        begin n_fail++; $display("FAIL bp_hold%0d: valid=%b id=%h fn=%h ack=%b required 1 55 66 0000", c, call_valid, call_id, call_fn, ch_ack); end
    end
    call_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (call_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accept: valid=%b required 0", call_valid); end
    bdata[0] = 32'h77;
    run_rsp(32'h9, 1);
    n_chk++; if (ch_ack !== 4'b0001 || ch_ret !== 32'h9 || ch_data[31:0] !== 32'h77)
      begin n_fail++; $display("FAIL bp_ack: ack=%b ret=%h w0=%h required 0001 9 77", ch_ack, ch_ret, ch_data[31:0]); end
    ch_req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_call();
    bit seen = 1'b0;
    apply_reset();
    ch_id[63:32] = 32'h1111; ch_id[127:96] = 32'h3333;
    ch_req = 4'b0100;
    wait_call("rst_mid");
    n_chk++; if (call_ch !== 2'd2) begin n_fail++; $display("FAIL rstmid_grant: ch=%0d required 2", call_ch); end
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_last = 1'b0; rsp_data = 32'hEE; rsp_ret = 32'h3;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || ch_ack !== 4'b0) begin n_fail++; $display("FAIL rstmid_idle: busy=%b ack=%b required 0 0000", busy, ch_ack); end
    @(posedge clk); #1;
    rst = 1'b0; ch_req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ch_ack !== 4'b0) seen = 1'b1;
    end
    n_chk++; if (seen) begin n_fail++; $display("FAIL rstmid_noack: ack seen=1 required 0"); end
    // Pointer back at 0: channel 1 wins over channel 3.
    ch_req = 4'b1010;
    wait_call("rst_next");
    n_chk++; if (call_ch !== 2'd1 || call_id !== 32'h1111) begin n_fail++; $display("FAIL rstmid_ptr: ch=%0d id=%h required 1 1111", call_ch, call_id); end
    @(posedge clk); #1;
    bdata[0] = 32'h44;
    run_rsp(32'h4, 1);
    n_chk++; if (ch_ack !== 4'b0010 || ch_ret !== 32'h4) begin n_fail++; $display("FAIL rstmid_ack: ack=%b ret=%h required 0010 4", ch_ack, ch_ret); end
    ch_req = 4'b0000;
    @(posedge clk); #1;
  endtask

`ifdef S2C_CALL_TIMEOUT_EN
  task automatic test_timeout();
    int cycles = 0;
    apply_reset();
    ch_req = 4'b0001;
    wait_call("timeout");
    @(posedge clk); #1;
    while (ch_ack === 4'b0 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    n_chk++; if (cycles !== 8) begin n_fail++; $display("FAIL to_cycles: got %0d required 8", cycles); end
    n_chk++; if (ch_ack !== 4'b0001 || ch_ret !== 32'hFFFF_FFFF || ch_err !== 1'b1)
      begin n_fail++; $display("FAIL to_ack: ack=%b ret=%h err=%b required 0001 ffffffff 1", ch_ack, ch_ret, ch_err); end
    ch_req = 4'b0000;
    rsp_valid = 1'b1; rsp_last = 1'b1; rsp_ret = 32'h5;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_last = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0 || ch_ack !== 4'b0) begin n_fail++; $display("FAIL to_late: busy=%b ack=%b required 0 0000", busy, ch_ack); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_call();
    test_round_robin();
    test_payload_bounds();
    test_backpressure();
    test_reset_mid_call();
`ifdef S2C_CALL_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
